// File: rtl/kiwi_wf_pkg.sv
// Shared types and helpers for the waterfall CIC control sequencer.
package kiwi_wf_pkg;

  localparam int unsigned DefMd       = 18;
  localparam int unsigned DefSettle   = 5;
  localparam int unsigned DefFrameLen = 1024;
  localparam int unsigned DefMaxZoom  = 14;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCfg     = 3'd1,
    StSettle  = 3'd2,
    StCapture = 3'd3,
    StDone    = 3'd4
  } wf_state_e;

  // Decimation word for a zoom level: 1 << min(zoom, max_zoom).
  function automatic logic [31:0] zoom_to_decim(input logic [3:0] zoom,
                                                input int unsigned max_zoom);
    int unsigned z;
    z = (32'(zoom) > max_zoom) ? max_zoom : 32'(zoom);
    return 32'd1 << z;
  endfunction

endpackage

// File: rtl/kiwi_wf_frame_gate.sv
// Capture-path gate: zero-latency pass-through of CIC samples while active,
// frame beat counter with TLAST, and the sticky overrun flag.
module kiwi_wf_frame_gate
  import kiwi_wf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAME_LEN  = DefFrameLen,
  parameter int unsigned CNT_WIDTH  = 11
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  active_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] s_tdata_i,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic                  m_tlast_o,
  output logic                  last_beat_o,
  output logic                  overrun_o
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 overrun_q;
  logic                 beat;

  // Pass-through handshake; outside capture every CIC sample is accepted and dropped.
  always_comb begin
    m_tdata_o   = s_tdata_i;
    m_tvalid_o  = active_i & s_tvalid_i;
    s_tready_o  = active_i ? m_tready_i : 1'b1;
    m_tlast_o   = active_i & (cnt_q == CNT_WIDTH'(FRAME_LEN - 1));
    beat        = m_tvalid_o & m_tready_i;
    last_beat_o = beat & m_tlast_o;
    overrun_o   = overrun_q;
  end

  // Beat counter and sticky overrun; the CIC cannot be back-pressured, so a stalled
  // downstream while a sample is offered means that sample is lost.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else if (start_i) begin
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (beat) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
      if (active_i && s_tvalid_i && !m_tready_i) begin
        overrun_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/kiwi_wf_ctrl.sv
// Waterfall CIC control sequencer: zoom -> CIC config write, settle-sample discard,
// then one gated frame per capture request.
module kiwi_wf_ctrl
  import kiwi_wf_pkg::*;
#(
  parameter int unsigned MD         = DefMd,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_ZOOM   = DefMaxZoom,
  parameter int unsigned SETTLE     = DefSettle,
  parameter int unsigned FRAME_LEN  = DefFrameLen,
  parameter int unsigned CNT_WIDTH  = 11
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [3:0]            zoom,
  input  logic                  zoom_wr,
  input  logic                  capture_start,
  output logic [MD-1:0]         m_axis_config_tdata,
  output logic                  m_axis_config_tvalid,
  input  logic                  m_axis_config_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
  input  logic                  s_axis_data_tvalid,
  output logic                  s_axis_data_tready,
  output logic [DATA_WIDTH-1:0] m_axis_data_tdata,
  output logic                  m_axis_data_tvalid,
  input  logic                  m_axis_data_tready,
  output logic                  m_axis_data_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int unsigned SettleW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  wf_state_e          state_q;
  logic [3:0]         zoom_q;
  logic               cfg_valid_q;
  logic               pending_q;
  logic               done_q;
  logic [SettleW-1:0] settle_q;

  logic cfg_hs;
  logic settle_last;
  logic start_req;
  logic enter_capture;
  logic last_beat;

  // Handshake and transition qualifiers shared by the FSM and the frame gate.
  always_comb begin
    cfg_hs        = (state_q == StCfg) & cfg_valid_q & m_axis_config_tready;
    settle_last   = (state_q == StSettle) & s_axis_data_tvalid &
                    (settle_q == SettleW'(1));
    start_req     = pending_q | capture_start;
    enter_capture = 1'b0;
    if (!zoom_wr) begin
      unique case (state_q)
        StIdle, StDone: enter_capture = capture_start;
        StCfg:          enter_capture = cfg_hs & (SETTLE == 0) & start_req;
        StSettle:       enter_capture = settle_last & start_req;
        default:        enter_capture = 1'b0;
      endcase
    end
  end

  // Main sequencer; zoom_wr preempts every state, including an in-flight frame.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      zoom_q      <= '0;
      cfg_valid_q <= 1'b0;
      pending_q   <= 1'b0;
      done_q      <= 1'b0;
      settle_q    <= '0;
    end else if (zoom_wr) begin
      zoom_q      <= zoom;
      cfg_valid_q <= 1'b1;
      done_q      <= 1'b0;
      pending_q   <= pending_q | capture_start;
      state_q     <= StCfg;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (capture_start) begin
            state_q <= StCapture;
          end
        end
        StCfg: begin
          if (capture_start) begin
            pending_q <= 1'b1;
          end
          if (cfg_hs) begin
            cfg_valid_q <= 1'b0;
            if (SETTLE == 0) begin
              state_q   <= start_req ? StCapture : StIdle;
              pending_q <= 1'b0;
            end else begin
              settle_q <= SettleW'(SETTLE);
              state_q  <= StSettle;
            end
          end
        end
        StSettle: begin
          if (capture_start) begin
            pending_q <= 1'b1;
          end
          if (settle_last) begin
            state_q   <= start_req ? StCapture : StIdle;
            pending_q <= 1'b0;
          end else if (s_axis_data_tvalid) begin
            settle_q <= settle_q - SettleW'(1);
          end
        end
        StCapture: begin
          if (last_beat) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          if (capture_start) begin
            state_q <= StCapture;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Config word follows the latched zoom; zoom_q=0 after reset gives a word of 1.
  always_comb begin
    m_axis_config_tdata  = MD'(zoom_to_decim(zoom_q, MAX_ZOOM));
    m_axis_config_tvalid = cfg_valid_q;
    busy                 = (state_q != StIdle) && (state_q != StDone);
    done                 = done_q;
  end

  kiwi_wf_frame_gate #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAME_LEN (FRAME_LEN),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_frame_gate (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .active_i   (state_q == StCapture),
    .start_i    (enter_capture),
    .s_tdata_i  (s_axis_data_tdata),
    .s_tvalid_i (s_axis_data_tvalid),
    .s_tready_o (s_axis_data_tready),
    .m_tdata_o  (m_axis_data_tdata),
    .m_tvalid_o (m_axis_data_tvalid),
    .m_tready_i (m_axis_data_tready),
    .m_tlast_o  (m_axis_data_tlast),
    .last_beat_o(last_beat),
    .overrun_o  (overrun)
  );

endmodule
